// File: rtl/spi_pkg.sv
// spi_pkg: SPI data width, master FSM state type and CLK_DIV limits.
// Shared by spi_master and the SPI slave benches.
package spi_pkg;

  localparam int SPI_DATA_W      = 8;
  localparam int SPI_CLK_DIV_MIN = 1;
  localparam int SPI_CLK_DIV_MAX = 255;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_HIGH,
    ST_LOW,
    ST_DONE
  } spi_state_e;

  function automatic bit clk_div_ok(input int div);
    return (div >= SPI_CLK_DIV_MIN) && (div <= SPI_CLK_DIV_MAX);
  endfunction

endpackage

// File: rtl/spi_clk_div.sv
// spi_clk_div: phase timer for the SPI master; flags the first and
// last clk cycle of each CLK_DIV-long SCK phase while enabled.
module spi_clk_div
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic en,
  output logic first,
  output logic tick
);

  if (!clk_div_ok(CLK_DIV)) begin : g_bad_div
    $error("spi_clk_div: CLK_DIV must be 1..255");
  end

  localparam int CNT_W = $clog2(CLK_DIV + 1);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(CLK_DIV - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign first = en && (cnt_q == '0);
  assign tick  = en && (cnt_q == LAST);

  // Reload on every phase end so each phase starts from zero.
  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (!en || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_master.sv
// spi_master: mode-0 SPI master, one byte per transfer, MSB first.
// Define SPI_MASTER_BURST_EN to keep SS low across back-to-back bytes.
module spi_master
  import spi_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [SPI_DATA_W-1:0] tx_data,
  output logic                  busy,
  output logic                  done,
  output logic [SPI_DATA_W-1:0] rx_data,
  output logic                  SCK,
  output logic                  MOSI,
  input  logic                  MISO,
  output logic                  SS
);

  localparam int BIT_W = $clog2(SPI_DATA_W);
  localparam logic [BIT_W-1:0] BIT_LAST =
    BIT_W'(SPI_DATA_W - 1);

  spi_state_e state_q, state_d;
  logic [SPI_DATA_W-1:0] tx_q, tx_d;
  logic [SPI_DATA_W-1:0] sh_q, sh_d;
  logic [SPI_DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BIT_W-1:0] bit_q, bit_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic sck_q, sck_d;
  logic mosi_q, mosi_d;
  logic ss_q, ss_d;
  logic ph_first;
  logic ph_tick;

  spi_clk_div #(
    .CLK_DIV(CLK_DIV)
  ) u_clk_div (
    .clk  (clk),
    .rst  (rst),
    .en   (busy_q),
    .first(ph_first),
    .tick (ph_tick)
  );

  always_comb begin
    state_d   = state_q;
    tx_d      = tx_q;
    sh_d      = sh_q;
    rx_data_d = rx_data_q;
    bit_d     = bit_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        state_d = ST_IDLE;
        if (start) begin
          state_d = ST_SETUP;
          tx_d    = tx_data;
          sh_d    = '0;
          bit_d   = '0;
        end
      end
      ST_SETUP: begin
        if (ph_tick) begin
          state_d = ST_HIGH;
        end
      end
      ST_HIGH: begin
        if (ph_first) begin
          sh_d = {sh_q[SPI_DATA_W-2:0], MISO};
        end
        if (ph_tick) begin
          state_d = ST_LOW;
          tx_d    = {tx_q[SPI_DATA_W-2:0], 1'b0};
        end
      end
      ST_LOW: begin
        if (ph_tick) begin
          bit_d   = bit_q + 1'b1;
          state_d = ST_HIGH;
          if (bit_q == BIT_LAST) begin
            state_d   = ST_DONE;
            rx_data_d = sh_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d == ST_SETUP) ||
             (state_d == ST_HIGH) ||
             (state_d == ST_LOW);
    done_d = (state_d == ST_DONE);
    sck_d  = (state_d == ST_HIGH);
    mosi_d = busy_d && tx_d[SPI_DATA_W-1];
`ifdef SPI_MASTER_BURST_EN
    ss_d   = !(busy_d || done_d);
`else
    ss_d   = !busy_d;
`endif
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= ST_IDLE;
      tx_q      <= '0;
      sh_q      <= '0;
      rx_data_q <= '0;
      bit_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      sck_q     <= 1'b0;
      mosi_q    <= 1'b0;
      ss_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      tx_q      <= tx_d;
      sh_q      <= sh_d;
      rx_data_q <= rx_data_d;
      bit_q     <= bit_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      sck_q     <= sck_d;
      mosi_q    <= mosi_d;
      ss_q      <= ss_d;
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign rx_data = rx_data_q;
  assign SCK     = sck_q;
  assign MOSI    = mosi_q;
  assign SS      = ss_q;

endmodule

// File: tb/tb_spi_master.sv
// tb_spi_master: directed vectors for spi_master at CLK_DIV=2 and 1,
// with a small mode-0 slave model on the CLK_DIV=2 instance.
`timescale 1ns/1ps
module tb_spi_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       start;
  logic [7:0] tx_data;
  logic       busy, done, sck, mosi, ss, miso;
  logic [7:0] rx_data;

  logic       start1;
  logic [7:0] tx1;
  logic       busy1, done1, sck1, mosi1, ss1;
  logic [7:0] rx1;

  spi_master #(.CLK_DIV(2)) u_dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .tx_data(tx_data),
    .busy   (busy),
    .done   (done),
    .rx_data(rx_data),
    .SCK    (sck),
    .MOSI   (mosi),
    .MISO   (miso),
    .SS     (ss)
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .clk    (clk),
    .rst    (rst),
    .start  (start1),
    .tx_data(tx1),
    .busy   (busy1),
    .done   (done1),
    .rx_data(rx1),
    .SCK    (sck1),
    .MOSI   (mosi1),
    .MISO   (1'b1),
    .SS     (ss1)
  );

`ifdef SPI_MASTER_BURST_EN
  localparam logic SS_IN_DONE = 1'b0;
`else
  localparam logic SS_IN_DONE = 1'b1;
`endif

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int rises = 0;
  int falls = 0;
  int dones = 0;
  int rises1 = 0;
  int last1  = 0;
  int gap1   = 0;

  logic [7:0] slv_data = 8'h00;
  int         slv_base = 0;
  logic [7:0] slv_in = 8'h00;
  logic [2:0] sidx;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) if (done) dones <= dones + 1;

  // Mode-0 slave: capture on SCK rise, shift out on SCK fall.
  always @(posedge sck) begin
    rises  <= rises + 1;
    slv_in <= {slv_in[6:0], mosi};
  end
  always @(negedge sck) falls <= falls + 1;
  assign sidx = 3'(7 - (falls - slv_base));
  assign miso = slv_data[sidx];

  always @(posedge sck1) begin
    rises1 <= rises1 + 1;
    gap1   <= cyc - last1;
    last1  <= cyc;
  end

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic wait_done(input string nm);
    int k;
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk({nm, "_seen"}, 32'(done), 1);
  endtask

  task automatic xfer(input logic [7:0] tx,
                      input logic [7:0] sd,
                      input logic [7:0] erx,
                      input logic [7:0] eso,
                      input string nm);
    int t0, r0;
    @(negedge clk);
    tx_data = tx;
    slv_data = sd;
    slv_base = falls;
    start = 1'b1;
    t0 = cyc;
    r0 = rises;
    @(negedge clk);
    start = 1'b0;
    tx_data = ~tx;
    chk({nm, "_setup"}, {ss, sck, busy, mosi},
        {1'b0, 1'b0, 1'b1, tx[7]});
    wait_done(nm);
    chk({nm, "_lat"}, cyc - t0, 35);
    chk({nm, "_rx"}, rx_data, erx);
    chk({nm, "_slv"}, slv_in, eso);
    chk({nm, "_rises"}, rises - r0, 8);
    chk({nm, "_donepins"}, {ss, sck, mosi, busy},
        {SS_IN_DONE, 3'b000});
    @(negedge clk);
    chk({nm, "_after"}, {done, ss, rx_data},
        {2'b01, erx});
  endtask

  typedef struct {
    logic [7:0] tx;
    logic [7:0] sd;
    logic [7:0] erx;
    logic [7:0] eso;
  } vec_t;

  vec_t vt[5];

  initial begin
    int t0, r0, d0, k;
    vt[0] = '{8'hA5, 8'hB1, 8'hB1, 8'hA5};
    vt[1] = '{8'h00, 8'hFF, 8'hFF, 8'h00};
    vt[2] = '{8'hFF, 8'h00, 8'h00, 8'hFF};
    vt[3] = '{8'h81, 8'h7E, 8'h7E, 8'h81};
    vt[4] = '{8'h3C, 8'hC3, 8'hC3, 8'h3C};

    rst = 1'b0;
    start = 1'b0;
    tx_data = 8'h00;
    start1 = 1'b0;
    tx1 = 8'h00;
    repeat (3) @(negedge clk);
    chk("reset_pins", {ss, sck, mosi, busy, done},
        5'b10000);
    chk("reset_rx", rx_data, 8'h00);
    chk("reset_pins1", {ss1, sck1, mosi1, busy1, done1},
        5'b10000);
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 5; i++) begin
      xfer(vt[i].tx, vt[i].sd, vt[i].erx, vt[i].eso,
           $sformatf("vec%0d", i));
    end

    // Back-to-back with start held through the DONE cycle.
    @(negedge clk);
    tx_data = 8'h3C;
    slv_data = 8'h1F;
    slv_base = falls;
    start = 1'b1;
    t0 = cyc;
    @(negedge clk);
    tx_data = 8'hF0;
    wait_done("b2b1");
    chk("b2b1_lat", cyc - t0, 35);
    chk("b2b1_rx", rx_data, 8'h1F);
    chk("b2b1_slv", slv_in, 8'h3C);
    chk("b2b1_ss", ss, SS_IN_DONE);
    slv_data = 8'hEA;
    slv_base = falls;
    t0 = cyc;
    r0 = rises;
    @(negedge clk);
    start = 1'b0;
    chk("b2b2_setup", {ss, busy, mosi}, 3'b011);
    wait_done("b2b2");
    chk("b2b2_lat", cyc - t0, 35);
    chk("b2b2_rx", rx_data, 8'hEA);
    chk("b2b2_slv", slv_in, 8'hF0);
    chk("b2b2_rises", rises - r0, 8);
    @(negedge clk);
    chk("b2b2_ssup", ss, 1'b1);

    // start pulsed mid-transfer is ignored.
    @(negedge clk);
    tx_data = 8'h5A;
    slv_data = 8'hC3;
    slv_base = falls;
    start = 1'b1;
    t0 = cyc;
    d0 = dones;
    @(negedge clk);
    start = 1'b0;
    repeat (10) @(negedge clk);
    tx_data = 8'hFF;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done("mid");
    chk("mid_lat", cyc - t0, 35);
    chk("mid_rx", rx_data, 8'hC3);
    chk("mid_slv", slv_in, 8'h5A);
    repeat (40) @(negedge clk);
    chk("mid_dones", dones - d0, 1);
    chk("mid_idle", busy, 1'b0);

    // Reset during the 4th HIGH phase.
    @(negedge clk);
    tx_data = 8'hA5;
    slv_data = 8'hB1;
    slv_base = falls;
    start = 1'b1;
    r0 = rises;
    d0 = dones;
    @(negedge clk);
    start = 1'b0;
    k = 0;
    while (rises - r0 < 4 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("rst_in_high", {32'(rises - r0), 31'(0), sck},
        {32'd4, 31'(0), 1'b1});
    rst = 1'b0;
    @(negedge clk);
    chk("rst_pins", {ss, sck, busy, done, mosi}, 5'b10000);
    chk("rst_rx", rx_data, 8'h00);
    start = 1'b1;
    @(negedge clk);
    rst = 1'b1;
    start = 1'b0;
    @(negedge clk);
    chk("rst_start_ign", {busy, ss}, 2'b01);
    repeat (50) @(negedge clk);
    chk("rst_no_done", dones - d0, 0);

    // CLK_DIV=1 instance, MISO tied high.
    @(negedge clk);
    tx1 = 8'h00;
    start1 = 1'b1;
    t0 = cyc;
    r0 = rises1;
    @(negedge clk);
    start1 = 1'b0;
    chk("div1_setup", {ss1, sck1, busy1, mosi1}, 4'b0010);
    k = 0;
    while (!done1 && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("div1_seen", done1, 1'b1);
    chk("div1_lat", cyc - t0, 18);
    chk("div1_rx", rx1, 8'hFF);
    chk("div1_rises", rises1 - r0, 8);
    chk("div1_period", gap1, 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
